// File: rtl/eth_pkg.sv
// Purpose : shared types and constants for the Ethernet II transmit framer.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, header struct, framing/CRC constants, bit-reverse helper.
package eth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_HEADER,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } eth_state_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
    } eth_hdr_t;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [15:0] ETH_TPID_VLAN     = 16'h8100;
    localparam int          ETH_HDR_LEN       = 14;

    // Ethernet shifts bits LSB-first, so the CRC engine uses the reflected polynomial.
    function automatic logic [31:0] eth_bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Purpose : byte-serial IEEE 802.3 CRC-32 (reflected, init all-ones, no output inversion).
// Latency : state register updates on the clock edge that samples en=1.
// Backpressure: none; one byte per enabled cycle.
// Ports: clk, rst_n (async, active-low), clr (load init, wins over en), en, data[7:0], crc[31:0] (raw state).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_R = eth_bitrev32(ETH_CRC_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_nxt[0] ^ data[i]) begin
                crc_nxt = {1'b0, crc_nxt[31:1]} ^ POLY_R;
            end else begin
                crc_nxt = {1'b0, crc_nxt[31:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clr) begin
            crc_q <= ETH_CRC_INIT;
        end else if (en) begin
            crc_q <= crc_nxt;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_frame_tx.sv
// Purpose : Ethernet II transmit framer: preamble/SFD, header, payload, zero pad, FCS, inter-frame gap.
// Latency : registered outputs; i_start in cycle N gives the first preamble byte in cycle N+1.
// Backpressure: none toward the PHY; payload source must supply a byte every cycle o_pl_ready is high.
// Ports: clk, rst_n (async, active-low); i_start, i_dst_mac, i_src_mac, i_ether_type (latched on start);
//        i_pl_data/i_pl_valid/i_pl_last with o_pl_ready; o_data/o_tx_en toward the PHY;
//        status o_busy, o_done, o_underrun, o_truncated.
// Option : define ETH_FRAME_TX_VLAN_EN to add i_vlan_en/i_vlan_tci and 802.1Q tag insertion.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [15:0] i_ether_type,
`ifdef ETH_FRAME_TX_VLAN_EN
    input  logic        i_vlan_en,
    input  logic [15:0] i_vlan_tci,
`endif
    input  logic [7:0]  i_pl_data,
    input  logic        i_pl_valid,
    input  logic        i_pl_last,
    output logic        o_pl_ready,
    output logic [7:0]  o_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun,
    output logic        o_truncated
);

`ifdef ETH_FRAME_TX_VLAN_EN
    localparam int HDR_BITS = (ETH_HDR_LEN + 4) * 8;
`else
    localparam int HDR_BITS = ETH_HDR_LEN * 8;
`endif
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES);
    localparam logic [10:0] DONE_CNT = 11'(IFG_CYCLES - 1);

    // The FSM runs one cycle ahead of the pins: the state in cycle c
    // decides the byte that the output register presents in cycle c+1.
    eth_state_t          state_q, state_d;
    logic [10:0]         cnt_q, cnt_d, cnt_inc;
    logic                bad_fcs_q, bad_fcs_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_load_val;
    logic [7:0]          hdr_byte;
    logic [10:0]         hdr_last, min_cnt;
    logic                hdr_load, hdr_shift;
    logic                crc_clr, crc_en;
    logic [7:0]          crc_dat;
    logic [31:0]         crc, fcs_word;
    logic [7:0]          data_d;
    logic                tx_en_d, done_d, underrun_d, truncated_d;
    eth_hdr_t            hdr_in;
`ifdef ETH_FRAME_TX_VLAN_EN
    logic                vlan_q;
`endif

    always_comb begin
        hdr_in = '{dst: i_dst_mac, src: i_src_mac, etype: i_ether_type};
`ifdef ETH_FRAME_TX_VLAN_EN
        hdr_load_val = i_vlan_en ? {hdr_in.dst, hdr_in.src, ETH_TPID_VLAN, i_vlan_tci, hdr_in.etype}
                                 : {hdr_in, 32'h0};
`else
        hdr_load_val = hdr_in;
`endif
    end

`ifdef ETH_FRAME_TX_VLAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vlan_q <= 1'b0;
        end else if (hdr_load) begin
            vlan_q <= i_vlan_en;
        end
    end
    // A tagged frame carries 4 extra header bytes, so less payload is needed for 64 bytes.
    assign hdr_last = vlan_q ? 11'(ETH_HDR_LEN + 3) : 11'(ETH_HDR_LEN - 1);
    assign min_cnt  = vlan_q ? 11'(MIN_PAYLOAD - 4) : 11'(MIN_PAYLOAD);
`else
    assign hdr_last = 11'(ETH_HDR_LEN - 1);
    assign min_cnt  = 11'(MIN_PAYLOAD);
`endif

    // Header is shifted out MSB-first from a single register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
        end else if (hdr_load) begin
            hdr_q <= hdr_load_val;
        end else if (hdr_shift) begin
            hdr_q <= {hdr_q[HDR_BITS-9:0], 8'h00};
        end
    end

    assign hdr_byte   = hdr_q[HDR_BITS-1 -: 8];
    assign cnt_inc    = cnt_q + 11'd1;
    assign fcs_word   = bad_fcs_q ? crc : ~crc;
    assign o_pl_ready = (state_q == S_PAYLOAD);

    eth_crc32_d8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (crc_dat),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bad_fcs_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bad_fcs_q <= bad_fcs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bad_fcs_d   = bad_fcs_q;
        data_d      = 8'h00;
        tx_en_d     = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        truncated_d = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_dat     = 8'h00;
        hdr_load    = 1'b0;
        hdr_shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    hdr_load  = 1'b1;
                    crc_clr   = 1'b1;
                    bad_fcs_d = 1'b0;
                    data_d    = ETH_PREAMBLE_BYTE;
                    tx_en_d   = 1'b1;
                    cnt_d     = 11'd1;
                    state_d   = (PREAMBLE_LEN > 1) ? S_PREAMBLE : S_SFD;
                end
            end
            S_PREAMBLE: begin
                data_d  = ETH_PREAMBLE_BYTE;
                tx_en_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SFD: begin
                data_d  = ETH_SFD;
                tx_en_d = 1'b1;
                cnt_d   = '0;
                state_d = S_HEADER;
            end
            S_HEADER: begin
                data_d    = hdr_byte;
                tx_en_d   = 1'b1;
                crc_en    = 1'b1;
                crc_dat   = hdr_byte;
                hdr_shift = 1'b1;
                if (cnt_q == hdr_last) begin
                    cnt_d   = '0;
                    state_d = S_PAYLOAD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PAYLOAD: begin
                if (i_pl_valid) begin
                    data_d  = i_pl_data;
                    tx_en_d = 1'b1;
                    crc_en  = 1'b1;
                    crc_dat = i_pl_data;
                    cnt_d   = cnt_inc;
                    if (i_pl_last || (cnt_inc == MAX_CNT)) begin
                        truncated_d = !i_pl_last;
                        if (cnt_inc < min_cnt) begin
                            state_d = S_PAD;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_FCS;
                        end
                    end
                end else begin
                    // Underrun: emit the first FCS byte right away so tx_en stays
                    // contiguous; an uninverted CRC marks the frame as corrupt.
                    underrun_d = 1'b1;
                    bad_fcs_d  = 1'b1;
                    data_d     = crc[7:0];
                    tx_en_d    = 1'b1;
                    cnt_d      = 11'd1;
                    state_d    = S_FCS;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                if (cnt_inc == min_cnt) begin
                    cnt_d   = '0;
                    state_d = S_FCS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FCS: begin
                data_d  = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                if (cnt_q == 11'd3) begin
                    cnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_IFG: begin
                // The first IFG cycle still shows the last FCS byte on the pins,
                // hence IFG_CYCLES+1 cycles in this state.
                done_d = (cnt_q == DONE_CNT);
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data      <= 8'h00;
            o_tx_en     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_underrun  <= 1'b0;
            o_truncated <= 1'b0;
        end else begin
            o_data      <= data_d;
            o_tx_en     <= tx_en_d;
            o_busy      <= (state_d != S_IDLE);
            o_done      <= done_d;
            o_underrun  <= underrun_d;
            o_truncated <= truncated_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Purpose : directed self-checking bench for eth_frame_tx (MAX_PAYLOAD=64) and eth_crc32_d8.
// Latency : n/a.
// Backpressure: payload source answers o_pl_ready every cycle, with optional deliberate underrun.
module tb_eth_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [47:0] i_dst_mac, i_src_mac;
    logic [15:0] i_ether_type;
    logic [7:0]  i_pl_data;
    logic        i_pl_valid, i_pl_last;
    logic        o_pl_ready, o_tx_en, o_busy, o_done, o_underrun, o_truncated;
    logic [7:0]  o_data;

    logic        c_clr, c_en;
    logic [7:0]  c_data;
    logic [31:0] c_crc;

    always #5 clk = ~clk;

    eth_frame_tx #(.MAX_PAYLOAD(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_dst_mac    (i_dst_mac),
        .i_src_mac    (i_src_mac),
        .i_ether_type (i_ether_type),
`ifdef ETH_FRAME_TX_VLAN_EN
        .i_vlan_en    (1'b0),
        .i_vlan_tci   (16'h0000),
`endif
        .i_pl_data    (i_pl_data),
        .i_pl_valid   (i_pl_valid),
        .i_pl_last    (i_pl_last),
        .o_pl_ready   (o_pl_ready),
        .o_data       (o_data),
        .o_tx_en      (o_tx_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun),
        .o_truncated  (o_truncated)
    );

    eth_crc32_d8 u_crc_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (c_clr),
        .en    (c_en),
        .data  (c_data),
        .crc   (c_crc)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [7:0]  pl [0:127];
    logic [7:0]  cap [$];
    logic [7:0]  expq [$];
    logic [31:0] exp_fcs;
    int          tx_cycles, tx_runs, n_underrun, n_trunc, consumed, done_gap;
    logic        got_done, busy_at_done, busy_after, pre_rst_en;
    logic [13:0] rst_vec;

    localparam logic [47:0] SRC_MAC = 48'h0011_2233_4455;
    localparam logic [47:0] DST_MAC = 48'h02AA_BBCC_DDEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Expected wire image: preamble, SFD, header, n_pay payload bytes, zero pad up to pad_to, FCS.
    task automatic build_exp(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int n_pay, input int pad_to, input bit bad);
        logic [31:0] c;
        expq.delete();
        for (int k = 0; k < 7; k++) expq.push_back(8'h55);
        expq.push_back(8'hD5);
        for (int k = 5; k >= 0; k--) expq.push_back(dst[8*k +: 8]);
        for (int k = 5; k >= 0; k--) expq.push_back(src[8*k +: 8]);
        expq.push_back(et[15:8]);
        expq.push_back(et[7:0]);
        for (int k = 0; k < n_pay; k++) expq.push_back(pl[k]);
        for (int k = n_pay; k < pad_to; k++) expq.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int k = 8; k < expq.size(); k++) c = crc_upd(c, expq[k]);
        exp_fcs = bad ? c : ~c;
        for (int k = 0; k < 4; k++) expq.push_back(exp_fcs[8*k +: 8]);
    endtask

    task automatic cmp_frame(input string tag, input bit good);
        int          nbad;
        int          n;
        logic [31:0] got_fcs, r;
        n    = cap.size();
        nbad = 0;
        for (int k = 0; k < n && k < expq.size(); k++) if (cap[k] !== expq[k]) nbad++;
        chk({tag, "_len"}, n, expq.size());
        chk({tag, "_bytes_differing"}, nbad, 0);
        got_fcs = (n >= 4) ? {cap[n-1], cap[n-2], cap[n-3], cap[n-4]} : 32'h0;
        chk({tag, "_fcs"}, got_fcs, exp_fcs);
        if (good) begin
            r = 32'hFFFFFFFF;
            for (int k = 8; k < n; k++) r = crc_upd(r, cap[k]);
            chk({tag, "_crc_residue"}, r, 32'hDEBB20E3);
        end
    endtask

    // Drives one frame cycle by cycle (inputs set at negedge, outputs sampled at negedge).
    // A second i_start is raised mid-frame to confirm it is ignored while busy.
    task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int n_src, input bit send_last, input int drop_at, input int abort_at);
        int   idx, last_tx;
        logic prev_en;
        cap.delete();
        tx_cycles = 0; tx_runs = 0; n_underrun = 0; n_trunc = 0; done_gap = -1;
        got_done = 1'b0; busy_at_done = 1'b0; idx = 0; last_tx = 0; prev_en = 1'b0;
        i_dst_mac = dst; i_src_mac = src; i_ether_type = et;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) begin
                pre_rst_en = o_tx_en;
                #2 rst_n = 1'b0;
                #1 rst_vec = {o_data, o_tx_en, o_pl_ready, o_busy, o_done, o_underrun, o_truncated};
                i_start = 1'b0; i_pl_valid = 1'b0; i_pl_last = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                consumed = idx;
                return;
            end
            if (o_tx_en) begin
                cap.push_back(o_data);
                tx_cycles++;
                last_tx = cyc;
                if (!prev_en) tx_runs++;
            end
            prev_en = o_tx_en;
            if (o_underrun)  n_underrun++;
            if (o_truncated) n_trunc++;
            if (o_done) begin
                got_done     = 1'b1;
                busy_at_done = o_busy;
                done_gap     = cyc - last_tx;
                break;
            end
            i_start    = (cyc == 0) || (cyc == 30);
            i_pl_valid = (idx < n_src) && (idx != drop_at);
            i_pl_data  = i_pl_valid ? pl[idx] : 8'h00;
            i_pl_last  = send_last && (idx == n_src - 1);
            if (o_pl_ready && i_pl_valid) idx++;
        end
        consumed = idx;
        i_start = 1'b0; i_pl_valid = 1'b0; i_pl_last = 1'b0;
        @(negedge clk);
        busy_after = o_busy;
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 128; k++) pl[k] = 8'(k * 7 + 3);
    endtask

    initial begin
        logic [7:0] arp [0:27];
        rst_n = 1'b0; i_start = 1'b0; i_dst_mac = '0; i_src_mac = '0; i_ether_type = '0;
        i_pl_data = '0; i_pl_valid = 1'b0; i_pl_last = 1'b0;
        c_clr = 1'b0; c_en = 1'b0; c_data = '0;
        fill_pattern();

        // Reset state, held in reset and just after release.
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_data, o_tx_en, o_pl_ready, o_busy, o_done, o_underrun, o_truncated}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {o_data, o_tx_en, o_pl_ready, o_busy, o_done, o_underrun, o_truncated}, 0);

        // CRC engine on the standard check string "123456789".
        c_clr = 1'b1;
        @(negedge clk);
        c_clr = 1'b0;
        for (int k = 0; k < 9; k++) begin
            c_en = 1'b1; c_data = 8'h31 + 8'(k);
            @(negedge clk);
        end
        c_en = 1'b0;
        chk("crc_check_string", ~c_crc, 32'hCBF43926);

        // 46-byte payload: exactly minimum, no pad.
        run_frame(DST_MAC, SRC_MAC, 16'h88B5, 46, 1'b1, -1, -1);
        build_exp(DST_MAC, SRC_MAC, 16'h88B5, 46, 46, 1'b0);
        chk("f46_done_seen", got_done, 1);
        chk("f46_tx_cycles", tx_cycles, 72);
        chk("f46_tx_runs", tx_runs, 1);
        chk("f46_consumed", consumed, 46);
        chk("f46_done_gap", done_gap, 12);
        chk("f46_busy_at_done", busy_at_done, 1);
        chk("f46_busy_after", busy_after, 0);
        chk("f46_flags", {n_underrun, n_trunc}, 0);
        cmp_frame("f46", 1'b1);

        // 10-byte payload: 36 pad bytes.
        run_frame(DST_MAC, SRC_MAC, 16'h0800, 10, 1'b1, -1, -1);
        build_exp(DST_MAC, SRC_MAC, 16'h0800, 10, 46, 1'b0);
        chk("f10_tx_cycles", tx_cycles, 72);
        chk("f10_consumed", consumed, 10);
        cmp_frame("f10", 1'b1);

        // ARP request who-has 192.168.1.1 tell 192.168.1.10, broadcast.
        arp = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8, 8'h01, 8'h0A,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
        for (int k = 0; k < 28; k++) pl[k] = arp[k];
        run_frame(48'hFFFF_FFFF_FFFF, SRC_MAC, 16'h0806, 28, 1'b1, -1, -1);
        build_exp(48'hFFFF_FFFF_FFFF, SRC_MAC, 16'h0806, 28, 46, 1'b0);
        chk("arp_tx_cycles", tx_cycles, 72);
        cmp_frame("arp", 1'b1);
        fill_pattern();

        // Underrun after 20 payload bytes: corrupt FCS, no pad.
        run_frame(DST_MAC, SRC_MAC, 16'h88B5, 46, 1'b1, 20, -1);
        build_exp(DST_MAC, SRC_MAC, 16'h88B5, 20, 0, 1'b1);
        chk("urun_pulses", n_underrun, 1);
        chk("urun_tx_cycles", tx_cycles, 8 + 14 + 20 + 4);
        chk("urun_consumed", consumed, 20);
        cmp_frame("urun", 1'b0);

        // 100-byte source without last: truncated at 64.
        run_frame(DST_MAC, SRC_MAC, 16'h88B5, 100, 1'b0, -1, -1);
        build_exp(DST_MAC, SRC_MAC, 16'h88B5, 64, 0, 1'b0);
        chk("trunc_pulses", n_trunc, 1);
        chk("trunc_consumed", consumed, 64);
        chk("trunc_tx_cycles", tx_cycles, 90);
        cmp_frame("trunc", 1'b1);

        // Last coincides with the 64th byte: normal end, no truncation pulse.
        run_frame(DST_MAC, SRC_MAC, 16'h88B5, 64, 1'b1, -1, -1);
        build_exp(DST_MAC, SRC_MAC, 16'h88B5, 64, 0, 1'b0);
        chk("last64_trunc_pulses", n_trunc, 0);
        cmp_frame("last64", 1'b1);

        // Reset mid-payload, then a clean frame.
        run_frame(DST_MAC, SRC_MAC, 16'h88B5, 100, 1'b0, -1, 40);
        chk("abort_was_active", pre_rst_en, 1);
        chk("abort_outputs", rst_vec, 0);
        run_frame(SRC_MAC, DST_MAC, 16'h1234, 46, 1'b1, -1, -1);
        build_exp(SRC_MAC, DST_MAC, 16'h1234, 46, 46, 1'b0);
        chk("after_abort_done_seen", got_done, 1);
        chk("after_abort_tx_runs", tx_runs, 1);
        cmp_frame("after_abort", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
